// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator: state encoding, counter
// width and the tap positions inside the packed window word.
package window_gen_3x3_pkg;

  localparam int CNT_W = 10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FILL   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Tap index = window_row*3 + window_col; tap 0 is the top-left pixel.
  localparam int TAP_00 = 0;
  localparam int TAP_01 = 1;
  localparam int TAP_02 = 2;
  localparam int TAP_10 = 3;
  localparam int TAP_11 = 4;
  localparam int TAP_12 = 5;
  localparam int TAP_20 = 6;
  localparam int TAP_21 = 7;
  localparam int TAP_22 = 8;
  localparam int NUM_TAPS = 9;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// Single-port row memory with a registered read port; a write returns the
// previous content of the same address (read-before-write).
module line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Read data only moves on an access, so it keeps the last accessed word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (en) rd_data_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (en && we) mem[addr] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream. Emits one window
// per interior pixel, one cycle after the pixel that completes it.
module window_gen_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [DATA_W-1:0]   in_data,
  output logic                win_valid,
  output logic [9*DATA_W-1:0] win_data,
  output logic [9:0]          win_row,
  output logic [9:0]          win_col,
  output logic                frame_done
);
  import window_gen_3x3_pkg::*;

  // Handshake: a pixel is taken whenever in_valid=1 in a cycle where the
  // block accepts (in_sof always, otherwise only while a frame is open);
  // there is no backpressure, and win_valid is a single-cycle pulse.

  localparam int LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

  typedef logic [2:0][DATA_W-1:0] column_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]      cur_row, cur_col;
  logic                  accept, fire, last_pix;
  logic [DATA_W-1:0]     pix_q, pix_d;
  logic                  par_q, par_d;
  logic [1:0][2:0][DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0]     lb0_rd, lb1_rd;
  column_t               newest;
  logic [9*DATA_W-1:0]   win_comb, win_data_q, win_data_d;
  logic                  win_valid_q, win_valid_d;
  logic [CNT_W-1:0]      win_row_q, win_row_d, win_col_q, win_col_d;

  always_comb begin
    accept   = in_valid && (in_sof || state_q == ST_FILL || state_q == ST_STREAM);
    cur_row  = in_sof ? '0 : row_q;
    cur_col  = in_sof ? '0 : col_q;
    last_pix = accept && cur_row == LAST_ROW && cur_col == LAST_COL;
    fire     = accept && cur_row >= CNT_W'(2) && cur_col >= CNT_W'(2);

    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + CNT_W'(1);
      end else begin
        col_d = cur_col + CNT_W'(1);
        row_d = cur_row;
      end
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_FILL;
      ST_FILL: begin
        if (accept) begin
          if (in_sof) state_d = ST_FILL;
          else if (cur_row == CNT_W'(1) && cur_col == LAST_COL) state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          if (in_sof) state_d = ST_FILL;
          else if (last_pix) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = accept ? ST_FILL : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Row r is written into buffer r%2, whose old content is row r-2; the
  // other buffer still holds row r-1 at the same column.
  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk     (clk),
    .en      (accept),
    .we      (accept && !cur_row[0]),
    .addr    (cur_col[LB_AW-1:0]),
    .wr_data (in_data),
    .rd_data (lb0_rd)
  );

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .en      (accept),
    .we      (accept && cur_row[0]),
    .addr    (cur_col[LB_AW-1:0]),
    .wr_data (in_data),
    .rd_data (lb1_rd)
  );

  // The newest column is assembled after the buffer read returns, so the
  // two older columns shift in from it on the following accepted pixel.
  always_comb begin
    newest[0] = par_q ? lb1_rd : lb0_rd;
    newest[1] = par_q ? lb0_rd : lb1_rd;
    newest[2] = pix_q;

    pix_d = accept ? in_data : pix_q;
    par_d = accept ? cur_row[0] : par_q;
    sr_d  = sr_q;
    if (accept) begin
      sr_d[0] = sr_q[1];
      sr_d[1] = newest;
    end

    win_comb = '0;
    win_comb[TAP_00*DATA_W +: DATA_W] = sr_q[0][0];
    win_comb[TAP_01*DATA_W +: DATA_W] = sr_q[1][0];
    win_comb[TAP_02*DATA_W +: DATA_W] = newest[0];
    win_comb[TAP_10*DATA_W +: DATA_W] = sr_q[0][1];
    win_comb[TAP_11*DATA_W +: DATA_W] = sr_q[1][1];
    win_comb[TAP_12*DATA_W +: DATA_W] = newest[1];
    win_comb[TAP_20*DATA_W +: DATA_W] = sr_q[0][2];
    win_comb[TAP_21*DATA_W +: DATA_W] = sr_q[1][2];
    win_comb[TAP_22*DATA_W +: DATA_W] = newest[2];

    win_valid_d = fire;
    win_row_d   = fire ? cur_row - CNT_W'(1) : win_row_q;
    win_col_d   = fire ? cur_col - CNT_W'(1) : win_col_q;
    win_data_d  = win_valid_q ? win_comb : win_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_data_q  <= win_data_d;
    end
  end

  always_ff @(posedge clk) begin
    pix_q <= pix_d;
    par_q <= par_d;
    sr_q  <= sr_d;
  end

  // During the pulse the window is taken straight from the column registers;
  // win_data_q keeps it for the idle cycles that follow.
  assign win_data   = win_data_d;
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomised frame stimulus against a pixel-array reference model; a monitor
// pops expected windows and their expected arrival cycles.
module tb_window_gen_3x3;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int IW = 9*DW + 21;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              win_valid;
  logic [9*DW-1:0]   win_data;
  logic [9:0]        win_row, win_col;
  logic              frame_done;

  window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_q[$];
  int unsigned   exp_cyc_q[$];
  int exp_done = 0;
  int seen_done = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] img [H][W];

  // reference model: every interior centre whose bottom-right pixel was sent
  task automatic push_windows(input int n_pix);
    logic [9*DW-1:0] d;
    logic fd;
    for (int r = 1; r < H-1; r++) begin
      for (int c = 1; c < W-1; c++) begin
        if ((r+1)*W + (c+1) < n_pix) begin
          d = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              d[(i*3+j)*DW +: DW] = img[r-1+i][c-1+j];
          fd = (n_pix == W*H) && (r == H-2) && (c == W-2);
          exp_q.push_back({fd, 10'(r), 10'(c), d});
        end
      end
    end
    if (n_pix == W*H) exp_done++;
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic drive_pix(input logic sof, input logic [DW-1:0] d, input bit win_exp, input int gap);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    if (win_exp) exp_cyc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int n_pix, input int gap_mode, input bit rnd);
    int r, c, g;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++)
        img[rr][cc] = rnd ? DW'($urandom) : DW'(rr*16 + cc);
    push_windows(n_pix);
    for (int k = 0; k < n_pix; k++) begin
      r = k / W;
      c = k % W;
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
      drive_pix(k == 0, img[r][c], (r >= 2) && (c >= 2), g);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== '0 ||
        win_row !== 10'd0 || win_col !== 10'd0) begin
      errors++;
      $display("FAIL %s: got valid=%b done=%b data=%h row=%0d col=%0d, want all zero",
               name, win_valid, frame_done, win_data, win_row, win_col);
    end
  endtask

  // scoreboard monitor
  logic [9*DW-1:0] hold_data = '0;
  logic [9:0]      hold_row = '0, hold_col = '0;
  bit              rst_pend = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_pend) begin
        hold_data = '0; hold_row = '0; hold_col = '0;
        rst_pend = 1'b0;
      end
      if (win_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got row=%0d col=%0d data=%h, want no window",
                   win_row, win_col, win_data);
        end else begin
          logic [IW-1:0] e;
          e = exp_q.pop_front();
          if ({frame_done, win_row, win_col, win_data} !== e) begin
            errors++;
            $display("FAIL window: got done=%b row=%0d col=%0d data=%h, want done=%b row=%0d col=%0d data=%h",
                     frame_done, win_row, win_col, win_data,
                     e[IW-1], e[IW-2 -: 10], e[IW-12 -: 10], e[9*DW-1:0]);
          end
        end
        checks++;
        if (exp_cyc_q.size() == 0) begin
          errors++;
          $display("FAIL latency: got window at cycle %0d, want none", cyc);
        end else begin
          int unsigned t;
          t = exp_cyc_q.pop_front();
          if (cyc != t) begin
            errors++;
            $display("FAIL latency: got cycle %0d, want cycle %0d", cyc, t);
          end
        end
        hold_data = win_data; hold_row = win_row; hold_col = win_col;
      end else begin
        checks++;
        if (frame_done !== 1'b0 || win_data !== hold_data || win_row !== hold_row ||
            win_col !== hold_col) begin
          errors++;
          $display("FAIL idle_hold: got done=%b data=%h row=%0d col=%0d, want done=0 data=%h row=%0d col=%0d",
                   frame_done, win_data, win_row, win_col, hold_data, hold_row, hold_col);
        end
      end
      if (frame_done === 1'b1) seen_done++;
      if (rst_n === 1'b0) rst_pend = 1'b1;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_init");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // full frame, continuous, then with the 1,0,0 valid pattern
    send_frame(W*H, 0, 1'b0);
    idle(3);
    send_frame(W*H, 1, 1'b0);
    idle(2);

    // pixels without in_sof while idle are ignored
    for (int k = 0; k < 10; k++) drive_pix(1'b0, DW'($urandom), 1'b0, 0);
    send_frame(W*H, 0, 1'b0);
    idle(2);

    // restart: new in_sof lands where pixel (3,4) would be
    send_frame(3*W + 4, 0, 1'b0);
    send_frame(W*H, 0, 1'b0);
    idle(2);

    // one-cycle reset while pixel (4,5) is presented
    send_frame(4*W + 5, 0, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_data  = img[4][5];
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_frame");
    @(posedge clk); #1;
    send_frame(W*H, 0, 1'b0);

    // back-to-back frames, second in_sof right after the DONE cycle
    idle(1);
    send_frame(W*H, 0, 1'b0);
    idle(1);
    send_frame(W*H, 0, 1'b0);
    idle(2);

    // random data with random gaps
    for (int f = 0; f < 3; f++) begin
      send_frame(W*H, 2, 1'b1);
      idle(int'($urandom_range(1, 3)));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d windows and %0d timestamps outstanding, want 0",
               exp_q.size(), exp_cyc_q.size());
    end
    checks++;
    if (seen_done != exp_done) begin
      errors++;
      $display("FAIL frame_done_count: got %0d, want %0d", seen_done, exp_done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
